// File: rtl/prime_table_engine.sv
// prime_table_engine: bus-mapped peripheral that fills a table with every prime up to LIMIT
// Ports:
//   iClk, iReset_n      clock and asynchronous active-low reset
//   iChip_select_n      active-low select qualifying iWrite_n / iRead_n
//   iWrite_n, iRead_n   active-low strobes (write wins over read)
//   iAddress            register: 0 CTRL, 1 LIMIT, 2 STATUS, 3 INDEX, 4 DATA
//   iData, oData        write data in, registered read data out
module prime_table_engine #(
    parameter int DATA_W = 32,
    parameter int MAX_W = 16,
    parameter int DEPTH = 256,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iChip_select_n,
    input  logic              iWrite_n,
    input  logic              iRead_n,
    input  logic [2:0]        iAddress,
    input  logic [DATA_W-1:0] iData,
    output logic [DATA_W-1:0] oData
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = $clog2(MAX_W);
    localparam logic [BW-1:0] BLAST = BW'(MAX_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_NEXT, S_TEST, S_MOD, S_EVAL, S_STORE, S_FIN} state_t;

    state_t            state;
    logic [MAX_W-1:0]  primes [DEPTH];
    logic [MAX_W-1:0]  limit, cand, dvs, dvd, rem, tk;
    logic [CNT_W-1:0]  index, count, k, count_inc;
    logic [BW-1:0]     bcnt;
    logic              busy, done, ovf, aborted;
    logic              wr, rd, start, abort;
    logic [MAX_W:0]    cand_inc, rem_sh, rem_sub;
    logic [MAX_W-1:0]  rem_nx;
    logic [2*MAX_W-1:0] sq;
    logic [DATA_W-1:0] rdata;
    logic              unused_bits;

    assign wr = !iChip_select_n && !iWrite_n;
    assign rd = !iChip_select_n && !iRead_n && iWrite_n;
    assign abort = wr && iAddress == 3'd0 && iData[1];
    assign start = wr && iAddress == 3'd0 && iData[0] && !iData[1];

    // k < count guards the table read so unwritten or out-of-range entries are never used
    assign tk = (k < count) ? primes[k[AW-1:0]] : '0;
    assign sq = {{MAX_W{1'b0}}, tk} * {{MAX_W{1'b0}}, tk};
    assign cand_inc = {1'b0, cand} + (MAX_W+1)'(1);
    assign count_inc = count + CNT_W'(1);

    // one restoring-division step: shift in the next dividend bit, subtract if it fits
    assign rem_sh = {rem, dvd[MAX_W-1]};
    assign rem_sub = rem_sh - {1'b0, dvs};
    assign rem_nx = rem_sub[MAX_W] ? rem_sh[MAX_W-1:0] : rem_sub[MAX_W-1:0];
    assign unused_bits = ^{iData, rem_sh[MAX_W]};

    always_comb begin
        rdata = '0;
        case (iAddress)
            3'd1: rdata = DATA_W'(limit);
            3'd2: begin
                rdata[3:0] = {aborted, ovf, done, busy};
                rdata[16 +: CNT_W] = count;
            end
            3'd3: rdata = DATA_W'(index);
            3'd4: rdata = (index < count) ? DATA_W'(primes[index[AW-1:0]]) : '0;
            default: rdata = '0;
        endcase
    end

    // the table has no reset; count alone decides which entries are valid
    always_ff @(posedge iClk) begin
        if (state == S_STORE && !abort)
            primes[count[AW-1:0]] <= cand;
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= S_IDLE;
            oData <= '0;
            limit <= '0;
            index <= '0;
            count <= '0;
            k <= '0;
            cand <= '0;
            dvs <= '0;
            dvd <= '0;
            rem <= '0;
            bcnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            ovf <= 1'b0;
            aborted <= 1'b0;
        end else begin
            if (rd)
                oData <= rdata;
            if (wr && iAddress == 3'd1 && !busy)
                limit <= iData[MAX_W-1:0];
            if (wr && iAddress == 3'd3)
                index <= iData[CNT_W-1:0];
            if (abort && busy) begin
                state <= S_IDLE;
                busy <= 1'b0;
                done <= 1'b0;
                aborted <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        count <= '0;
                        done <= 1'b0;
                        ovf <= 1'b0;
                        aborted <= 1'b0;
                        cand <= MAX_W'(1);
                        busy <= 1'b1;
                        state <= S_NEXT;
                    end
                    S_NEXT: if (cand_inc > {1'b0, limit} || &cand) begin
                        state <= S_FIN;
                    end else begin
                        cand <= cand_inc[MAX_W-1:0];
                        k <= '0;
                        state <= S_TEST;
                    end
                    S_TEST: if (k == count || sq > {{MAX_W{1'b0}}, cand}) begin
                        state <= S_STORE;
                    end else begin
                        dvs <= tk;
                        dvd <= cand;
                        rem <= '0;
                        bcnt <= '0;
                        state <= S_MOD;
                    end
                    S_MOD: begin
                        rem <= rem_nx;
                        dvd <= dvd << 1;
                        bcnt <= bcnt + BW'(1);
                        if (bcnt == BLAST)
                            state <= S_EVAL;
                    end
                    S_EVAL: if (rem == '0) begin
                        state <= S_NEXT;
                    end else begin
                        k <= k + CNT_W'(1);
                        state <= S_TEST;
                    end
                    S_STORE: begin
                        count <= count_inc;
                        if (count_inc == CNT_W'(DEPTH) && cand < limit) begin
                            ovf <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                    S_FIN: begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prime_table_engine.sv
// tb_prime_table_engine: randomized and directed checks of prime_table_engine against an arithmetic prime model
module tb_prime_table_engine;
    localparam int MW = 16;

    logic        clk = 1'b0;
    logic        rst0 = 1'b0, rst1 = 1'b0;
    logic        cs0 = 1'b1, cs1 = 1'b1;
    logic        wr_n = 1'b1, rd_n = 1'b1;
    logic [2:0]  addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout0, dout1;
    int          checks = 0, errors = 0, cyc = 0;
    logic        samp_rd = 1'b0;
    bit          rst_flag = 1'b1;
    logic [31:0] prev0;

    prime_table_engine #(.DATA_W(32), .MAX_W(MW), .DEPTH(256)) dut (
        .iClk(clk), .iReset_n(rst0), .iChip_select_n(cs0), .iWrite_n(wr_n),
        .iRead_n(rd_n), .iAddress(addr), .iData(din), .oData(dout0));

    prime_table_engine #(.DATA_W(32), .MAX_W(MW), .DEPTH(8)) dut8 (
        .iClk(clk), .iReset_n(rst1), .iChip_select_n(cs1), .iWrite_n(wr_n),
        .iRead_n(rd_n), .iAddress(addr), .iData(din), .oData(dout1));

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc++;
        samp_rd = !cs0 && !rd_n && wr_n;
    end

    // oData of the main instance must hold on every cycle that samples no read
    always @(negedge rst0) rst_flag = 1'b1;
    always @(negedge clk) begin
        if (!rst_flag && rst0 && !samp_rd) begin
            checks++;
            if (dout0 !== prev0) begin
                errors++;
                $display("FAIL odata_hold got %0h exp %0h at cycle %0d", dout0, prev0, cyc);
            end
        end
        rst_flag = 1'b0;
        prev0 = dout0;
    end

    function automatic bit is_prime(input int n);
        if (n < 2) return 0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 0;
        return 1;
    endfunction

    function automatic int pcount(input int n);
        int c = 0;
        for (int i = 2; i <= n; i++) if (is_prime(i)) c++;
        return c;
    endfunction

    function automatic int nth(input int idx);
        int c = 0;
        for (int n = 2; ; n++) if (is_prime(n)) begin
            if (c == idx) return n;
            c++;
        end
    endfunction

    function automatic int isqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // primes whose table write lands strictly before an abort sampled d cycles after START,
    // from the cost per candidate: NEXT + tested primes*(TEST+MOD+EVAL) + final TEST + STORE
    function automatic int stored_by(input int d);
        int t = 0, c = 0, tests, cost;
        bit pr;
        for (int n = 2; n < 65536; n++) begin
            tests = 0;
            pr = 1;
            for (int p = 2; p * p <= n; p++) if (is_prime(p)) begin
                tests++;
                if (n % p == 0) begin
                    pr = 0;
                    break;
                end
            end
            cost = 1 + tests * (MW + 2) + (pr ? 2 : 0);
            t += cost;
            if (t >= d) break;
            if (pr) c++;
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic sel(input int d);
        if (d == 0) cs0 = 1'b0; else cs1 = 1'b0;
    endtask

    task automatic wr_reg(input int d, input logic [2:0] a, input logic [31:0] v);
        addr = a; din = v; wr_n = 1'b0; rd_n = 1'b1; sel(d);
        @(negedge clk);
        cs0 = 1'b1; cs1 = 1'b1; wr_n = 1'b1;
    endtask

    task automatic rd_reg(input int d, input logic [2:0] a, output logic [31:0] v);
        addr = a; rd_n = 1'b0; wr_n = 1'b1; sel(d);
        @(negedge clk);
        v = (d == 0) ? dout0 : dout1;
        cs0 = 1'b1; cs1 = 1'b1; rd_n = 1'b1;
    endtask

    task automatic poll(input int d, input int lim, output logic [31:0] s);
        int bound, t0;
        bound = lim * (isqrt(lim) + 1) * (MW + 3) + 64;
        t0 = cyc;
        do rd_reg(d, 3'd2, s); while (s[0] && cyc - t0 < bound);
        checks++;
        if (s[0]) begin
            errors++;
            $display("FAIL poll_timeout limit %0d still busy after %0d cycles", lim, cyc - t0);
        end
    endtask

    task automatic run(input int d, input int lim);
        logic [31:0] s, v;
        int np, cnt, ov, dep;
        dep = d ? 8 : 256;
        wr_reg(d, 3'd1, lim);
        wr_reg(d, 3'd0, 1);
        poll(d, lim, s);
        np = pcount(lim);
        cnt = (np < dep) ? np : dep;
        ov = (np >= dep && nth(dep - 1) < lim) ? 1 : 0;
        chk($sformatf("status_d%0d_l%0d", dep, lim), s, (cnt << 16) | (ov << 2) | 2);
        for (int i = 0; i < cnt; i++) begin
            wr_reg(d, 3'd3, i);
            rd_reg(d, 3'd4, v);
            chk($sformatf("entry_d%0d_l%0d_i%0d", dep, lim, i), v, nth(i));
        end
        wr_reg(d, 3'd3, cnt);
        rd_reg(d, 3'd4, v);
        chk($sformatf("entry_past_d%0d_l%0d", dep, lim), v, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, s;
        int exp30[10] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
        int ts, d, c;
        repeat (2) @(negedge clk);
        chk("reset_odata0", dout0, 0);
        chk("reset_odata1", dout1, 0);
        rst0 = 1'b1; rst1 = 1'b1;
        @(negedge clk);
        rd_reg(0, 3'd2, v); chk("reset_status", v, 0);
        rd_reg(0, 3'd1, v); chk("reset_limit", v, 0);
        rd_reg(0, 3'd3, v); chk("reset_index", v, 0);
        rd_reg(1, 3'd4, v); chk("reset_data8", v, 0);

        wr_reg(0, 3'd1, 30);
        rd_reg(0, 3'd1, v); chk("limit_rw", v, 30);
        rd_reg(0, 3'd5, v); chk("addr5", v, 0);
        addr = 3'd1; rd_n = 1'b0; cs0 = 1'b0;
        #1 chk("latency_pre", dout0, 0);
        @(posedge clk);
        #1 chk("latency_post", dout0, 30);
        @(negedge clk);
        addr = 3'd3; din = 5; wr_n = 1'b0;
        @(negedge clk);
        cs0 = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        chk("rw_hold", dout0, 30);
        rd_reg(0, 3'd3, v); chk("rw_write_applied", v, 5);
        addr = 3'd1; rd_n = 1'b0;
        @(negedge clk);
        rd_n = 1'b1;
        chk("deselected_read", dout0, 5);
        rd_reg(0, 3'd1, v);
        rd_reg(0, 3'd6, v); chk("addr6", v, 0);
        rd_reg(0, 3'd1, v);
        rd_reg(0, 3'd7, v); chk("addr7", v, 0);

        run(0, 30);
        rd_reg(0, 3'd2, v); chk("l30_status_lit", v, (10 << 16) | 2);
        for (int i = 0; i < 10; i++) begin
            wr_reg(0, 3'd3, i);
            rd_reg(0, 3'd4, v);
            chk($sformatf("l30_lit_%0d", i), v, exp30[i]);
        end
        run(0, 1);
        run(0, 2);
        wr_reg(0, 3'd3, 0);
        rd_reg(0, 3'd4, v); chk("l2_entry0_lit", v, 2);
        run(1, 100);
        rd_reg(1, 3'd2, v); chk("d8_l100_status_lit", v, (8 << 16) | 4 | 2);
        wr_reg(1, 3'd3, 7);
        rd_reg(1, 3'd4, v); chk("d8_entry7_lit", v, 19);
        run(1, 19);
        rd_reg(1, 3'd2, v); chk("d8_l19_status_lit", v, (8 << 16) | 2);
        for (int r = 0; r < 6; r++)
            run(r % 2, (r % 2) ? $urandom_range(0, 40) : $urandom_range(0, 120));

        wr_reg(0, 3'd1, 1000);
        wr_reg(0, 3'd0, 1);
        ts = cyc;
        rd_reg(0, 3'd2, s); chk("busy_after_start", s, 1);
        wr_reg(0, 3'd1, 7);
        while (cyc - ts < 500) @(negedge clk);
        wr_reg(0, 3'd0, 2);
        d = cyc - ts;
        c = stored_by(d);
        rd_reg(0, 3'd2, s); chk("abort_status", s, (c << 16) | 8);
        for (int i = 0; i < c; i++) begin
            wr_reg(0, 3'd3, i);
            rd_reg(0, 3'd4, v);
            chk($sformatf("abort_entry_%0d", i), v, nth(i));
        end
        rd_reg(0, 3'd1, v); chk("limit_write_ignored", v, 1000);
        wr_reg(0, 3'd0, 1);
        rd_reg(0, 3'd2, s); chk("restart_clears_aborted", s, 1);
        wr_reg(0, 3'd0, 3);
        rd_reg(0, 3'd2, s); chk("start_abort_is_abort", s, 8);
        wr_reg(0, 3'd0, 2);
        rd_reg(0, 3'd2, s); chk("idle_abort_noop", s, 8);

        wr_reg(0, 3'd1, 500);
        wr_reg(0, 3'd0, 1);
        wr_reg(0, 3'd3, 2);
        repeat (200) @(negedge clk);
        #2 rst0 = 1'b0;
        #1 chk("midrun_reset_odata", dout0, 0);
        #1 rst0 = 1'b1;
        @(negedge clk);
        rd_reg(0, 3'd2, v); chk("midrun_reset_status", v, 0);
        rd_reg(0, 3'd1, v); chk("midrun_reset_limit", v, 0);
        rd_reg(0, 3'd3, v); chk("midrun_reset_index", v, 0);
        rd_reg(0, 3'd4, v); chk("midrun_reset_data", v, 0);
        repeat (40) @(negedge clk);
        rd_reg(0, 3'd2, v); chk("midrun_reset_no_completion", v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
